apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- APB completer (slave) sitting on the peripheral side of the AHB-to-APB bridge. It answers the bridge's Pselx/Penable/Pwrite/Paddr/Pwdata transfers and returns Prdata.
- Backed by a word-addressed register bank. Supports programmable wait states (Pready), error response (Pslverr) and a sticky protocol-violation flag for verification.
- One instance per Pselx line. Prdata and Pready are zero-gated when the instance is not selected, so the outputs of all instances can be OR-combined.

Parameters:
- SEL_BIT, 0, index of the Pselx bit this instance responds to (0..2).
- BASE_ADDR, 32'h8000_0000, byte base address of the bank.
- DEPTH, 16, number of 32-bit words; power of 2, 2..256.
- WAIT_CYCLES, 0, number of access-phase cycles with Pready low before completion (0..15).

Ports:
- Hclk  in  1  clock, rising edge.
- Hresetn  in  1  asynchronous, active-low reset.
- Pselx  in  3  peripheral selects from the bridge; only bit SEL_BIT is used.
- Penable  in  1  APB enable (access phase).
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  byte address.
- Pwdata  in  32  write data.
- Prdata  out  32  read data.
- Pready  out  1  transfer complete in the current access cycle.
- Pslverr  out  1  error response; valid only when Pready = 1.
- prot_err  out  1  sticky APB protocol violation flag.
- xfer_count  out  16  count of completed transfers (OK or error); wraps at 16'hFFFF -> 0.

Behaviour:
- sel = Pselx[SEL_BIT].
- Reset (async, Hresetn = 0):
  - state = IDLE.
  - All mem words = 0; rd_q = 0; wait counter = 0.
  - Prdata = 0, Pready = 0, Pslverr = 0, prot_err = 0, xfer_count = 0.
  - Reset in the middle of a transfer aborts it; no memory write is committed.
- Decode, evaluated when the setup phase is captured:
  - off = Paddr - BASE_ADDR (32-bit, unsigned).
  - err = (Paddr[1:0] != 0) OR (off >= DEPTH*4), the second term covering addresses below BASE (underflow wraps high).
  - idx = off[log2(DEPTH)+1:2].
- FSM, states IDLE and ACCESS:
  - IDLE, sel & !Penable at the edge (setup phase):
    - latch Paddr, Pwrite and err; clear wait counter; go to ACCESS.
    - if read and !err, rd_q <= mem[idx]; if read and err, rd_q <= 0.
  - IDLE, sel & Penable (access without setup): set prot_err; no state change; no write.
  - ACCESS, sel & Penable with unchanged Paddr/Pwrite:
    - Pready = (counter == WAIT_CYCLES), combinational from the state.
    - not ready: counter increments at the edge.
    - ready: transfer completes at the edge. If write and !err, mem[idx] <= Pwdata sampled at that edge. xfer_count increments. Go to IDLE.
  - ACCESS, violation (sel drops, Penable low, or Paddr/Pwrite differs from the latched value): set prot_err; abort with no write and no count; go to IDLE.
    - if that same cycle is a new setup (sel & !Penable), it is captured in the same edge as a fresh transfer.
- Back-to-back transfers: the standard setup phase following a completion is accepted without an idle cycle.
- Throughput: WAIT_CYCLES = 0 gives 2 cycles per transfer; each wait state adds 1 cycle.
- Output gating:
  - Prdata = (sel & state == ACCESS & !latched Pwrite) ? rd_q : 0.
  - Pslverr = Pready & latched err.
  - Pready = 0 outside ACCESS.
- Write and read in consecutive transfers to the same idx return the new data. The write commits at completion, before the next setup edge.
- prot_err clears only on reset.

Test Plan:
- Reset, then check all outputs: Prdata = 0, Pready = 0, prot_err = 0, xfer_count = 0; a read of BASE+0x0 returns 0.
- WAIT_CYCLES = 0: write 32'hDEAD_BEEF to 32'h8000_0004, then read it back. Expect Pready high in the access cycle, Pslverr = 0, Prdata = 32'hDEAD_BEEF, xfer_count = 2, 4 cycles total.
- WAIT_CYCLES = 3: single read of 32'h8000_0008.
  - Pready low for 3 access cycles, high on the 4th.
  - Prdata stable across all wait cycles.
  - Transfer takes 5 cycles from setup.
- Error cases, each returning Pslverr = 1 with Pready:
  - write 32'h1234_5678 to 32'h8000_0040 (off = 64 ≥ DEPTH*4 with DEPTH = 16) commits nothing.
  - read of 32'h8000_0002 (misaligned) returns Prdata = 0.
  - read of 32'h7FFF_FFFC (below BASE) returns an error.
  - xfer_count increments for each.
- Protocol violation: Penable asserted with no preceding setup sets prot_err = 1. Dropping Penable mid-wait (WAIT_CYCLES = 2) aborts the write; a later read returns the old value; prot_err stays 1 until reset.
- Reset mid-operation and selection:
  - assert Hresetn = 0 during the access phase of a write to 32'h8000_000C: the word reads 0 after release.
  - with Pselx = 3'b010 and SEL_BIT = 0, the instance ignores all traffic (Prdata = 0, Pready = 0, no count).

Source files
------------

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer backed by a word-addressed register bank.
// Programmable wait states, error response and a sticky protocol flag.
module apb_slave_mem #(
   parameter int          SEL_BIT     = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          DEPTH       = 16,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic        Hclk,
   input  logic        Hresetn,
   input  logic [2:0]  Pselx,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        Pready,
   output logic        Pslverr,
   output logic        prot_err,
   output logic [15:0] xfer_count
);
   localparam int          AW     = $clog2(DEPTH);
   localparam logic [31:0] LIMIT  = 32'(DEPTH * 4);
   localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t        state;
   logic [31:0]   mem [DEPTH];
   logic [31:0]   addr_q;
   logic [31:0]   rd_q;
   logic [AW-1:0] idx_q;
   logic          write_q;
   logic          err_q;
   logic [3:0]    cnt_q;

   logic          sel;
   logic          setup;
   logic          access_ok;
   logic          capture;
   logic          err;
   logic [31:0]   off;
   logic [AW-1:0] idx;
   logic          unused_sel;

   assign sel        = Pselx[SEL_BIT];
   assign unused_sel = ^Pselx;
   assign setup      = sel & ~Penable;
   assign off        = Paddr - BASE_ADDR;
   // Addresses below the base wrap high and fail the range test.
   assign err        = (|Paddr[1:0]) | (off >= LIMIT);
   assign idx        = off[AW+1:2];

   assign access_ok = sel & Penable & (Paddr == addr_q) & (Pwrite == write_q);
   assign capture   = setup & ((state == IDLE) | ~access_ok);

   assign Pready  = sel & (state == ACCESS) & (cnt_q == WAIT_N);
   assign Pslverr = Pready & err_q;
   assign Prdata  = (sel & (state == ACCESS) & ~write_q) ? rd_q : '0;

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state      <= IDLE;
         addr_q     <= '0;
         idx_q      <= '0;
         write_q    <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         rd_q       <= '0;
         prot_err   <= 1'b0;
         xfer_count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (sel & Penable) prot_err <= 1'b1;
            end
            ACCESS: begin
               if (access_ok) begin
                  if (cnt_q == WAIT_N) begin
                     if (write_q & ~err_q) mem[idx_q] <= Pwdata;
                     xfer_count <= xfer_count + 16'd1;
                     state      <= IDLE;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end else begin
                  prot_err <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // A setup phase, including one arriving on an aborting cycle,
         // starts a fresh transfer.
         if (capture) begin
            state   <= ACCESS;
            addr_q  <= Paddr;
            idx_q   <= idx;
            write_q <= Pwrite;
            err_q   <= err;
            cnt_q   <= '0;
            rd_q    <= (!Pwrite && !err) ? mem[idx] : '0;
         end
      end
   end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: vector table plus directed sequences for three
// completers on one bus (0/3/2 wait states on select bits 0/1/2).
module tb_apb_slave_mem;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata [3];
   logic        pready [3];
   logic        pslverr [3];
   logic        perr [3];
   logic [15:0] xcnt [3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   apb_slave_mem #(.SEL_BIT(0), .WAIT_CYCLES(0)) u0 (
      .Hclk(clk), .Hresetn(rst_n), .Pselx(psel), .Penable(penable),
      .Pwrite(pwrite), .Paddr(paddr), .Pwdata(pwdata),
      .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]),
      .prot_err(perr[0]), .xfer_count(xcnt[0]));

   apb_slave_mem #(.SEL_BIT(1), .WAIT_CYCLES(3)) u1 (
      .Hclk(clk), .Hresetn(rst_n), .Pselx(psel), .Penable(penable),
      .Pwrite(pwrite), .Paddr(paddr), .Pwdata(pwdata),
      .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]),
      .prot_err(perr[1]), .xfer_count(xcnt[1]));

   apb_slave_mem #(.SEL_BIT(2), .WAIT_CYCLES(2)) u2 (
      .Hclk(clk), .Hresetn(rst_n), .Pselx(psel), .Penable(penable),
      .Pwrite(pwrite), .Paddr(paddr), .Pwdata(pwdata),
      .Prdata(prdata[2]), .Pready(pready[2]), .Pslverr(pslverr[2]),
      .prot_err(perr[2]), .xfer_count(xcnt[2]));

   typedef struct {
      logic [2:0]  sel;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_waits;
   } vec_t;

   vec_t vec [14];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic xfer(input logic [2:0] s, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic [31:0] rd0,
                       output logic er, output int waits);
      int k;
      bit done;
      k = (s == 3'b001) ? 0 : (s == 3'b010) ? 1 : 2;
      done = 1'b0;
      rd = '0;
      rd0 = '0;
      er = 1'b0;
      waits = 0;
      psel = s;
      penable = 1'b0;
      pwrite = wr;
      paddr = a;
      pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (c == 0) rd0 = prdata[k];
         if (pready[k]) begin
            rd = prdata[k];
            er = pslverr[k];
            done = 1'b1;
         end else begin
            waits++;
         end
         @(posedge clk); #1;
      end
      psel = 3'b000;
      penable = 1'b0;
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: no Pready on %h after 20 cycles", a);
      end
   endtask

   initial begin
      logic [31:0] rd, rd0;
      logic        er;
      int          w;

      vec[0]  = '{3'b001, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 0};
      vec[1]  = '{3'b001, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 0};
      vec[2]  = '{3'b001, 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 0};
      vec[3]  = '{3'b001, 1'b1, 32'h8000_0040, 32'h1234_5678, 32'h0, 1'b1, 0};
      vec[4]  = '{3'b001, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 0};
      vec[5]  = '{3'b001, 1'b0, 32'h8000_0002, 32'h0, 32'h0, 1'b1, 0};
      vec[6]  = '{3'b001, 1'b0, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1, 0};
      vec[7]  = '{3'b001, 1'b1, 32'h8000_003C, 32'hA5A5_0001, 32'h0, 1'b0, 0};
      vec[8]  = '{3'b001, 1'b0, 32'h8000_003C, 32'h0, 32'hA5A5_0001, 1'b0, 0};
      vec[9]  = '{3'b001, 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 0};
      vec[10] = '{3'b010, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 1'b0, 3};
      vec[11] = '{3'b010, 1'b0, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 1'b0, 3};
      vec[12] = '{3'b100, 1'b1, 32'h8000_0010, 32'h1111_2222, 32'h0, 1'b0, 2};
      vec[13] = '{3'b100, 1'b0, 32'h8000_0010, 32'h0, 32'h1111_2222, 1'b0, 2};

      rst_n = 1'b0;
      psel = 3'b000;
      penable = 1'b0;
      pwrite = 1'b0;
      paddr = '0;
      pwdata = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_prdata%0d", k), prdata[k], 32'h0);
         chk($sformatf("rst_pready%0d", k), 32'(pready[k]), 32'h0);
         chk($sformatf("rst_pslverr%0d", k), 32'(pslverr[k]), 32'h0);
         chk($sformatf("rst_prot%0d", k), 32'(perr[k]), 32'h0);
         chk($sformatf("rst_count%0d", k), 32'(xcnt[k]), 32'h0);
      end
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         xfer(vec[i].sel, vec[i].wr, vec[i].addr, vec[i].wdata, rd, rd0, er, w);
         chk($sformatf("v%0d_rdata", i), rd, vec[i].exp_rd);
         chk($sformatf("v%0d_rdata_first", i), rd0, vec[i].exp_rd);
         chk($sformatf("v%0d_slverr", i), 32'(er), 32'(vec[i].exp_err));
         chk($sformatf("v%0d_waits", i), 32'(w), 32'(vec[i].exp_waits));
      end
      @(negedge clk);
      chk("count0", 32'(xcnt[0]), 32'd10);
      chk("count1", 32'(xcnt[1]), 32'd2);
      chk("count2", 32'(xcnt[2]), 32'd2);
      for (int k = 0; k < 3; k++)
         chk($sformatf("prot_clean%0d", k), 32'(perr[k]), 32'h0);
      @(posedge clk); #1;

      // access phase with no setup
      psel = 3'b001;
      penable = 1'b1;
      pwrite = 1'b1;
      paddr = 32'h8000_0000;
      pwdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      psel = 3'b000;
      penable = 1'b0;
      @(negedge clk);
      chk("nosetup_prot", 32'(perr[0]), 32'h1);
      chk("nosetup_count", 32'(xcnt[0]), 32'd10);
      chk("nosetup_prot_other", 32'(perr[1]), 32'h0);
      @(posedge clk); #1;
      xfer(3'b001, 1'b0, 32'h8000_0000, 32'h0, rd, rd0, er, w);
      chk("nosetup_nowrite", rd, 32'h0);

      // Penable dropped mid-wait on the two-wait-state instance
      psel = 3'b100;
      penable = 1'b0;
      pwrite = 1'b1;
      paddr = 32'h8000_0010;
      pwdata = 32'h9999_9999;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      chk("drop_wait_pready", 32'(pready[2]), 32'h0);
      @(posedge clk); #1;
      penable = 1'b0;
      @(posedge clk); #1;
      psel = 3'b000;
      @(posedge clk); #1;
      @(negedge clk);
      chk("drop_prot", 32'(perr[2]), 32'h1);
      chk("drop_count", 32'(xcnt[2]), 32'd2);
      @(posedge clk); #1;
      xfer(3'b100, 1'b0, 32'h8000_0010, 32'h0, rd, rd0, er, w);
      chk("drop_old_value", rd, 32'h1111_2222);
      chk("drop_read_waits", 32'(w), 32'd2);
      @(negedge clk);
      chk("drop_prot_sticky", 32'(perr[2]), 32'h1);
      chk("drop_count_after", 32'(xcnt[2]), 32'd3);
      @(posedge clk); #1;

      // reset during the access phase of a write
      psel = 3'b001;
      penable = 1'b0;
      pwrite = 1'b1;
      paddr = 32'h8000_000C;
      pwdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      penable = 1'b1;
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      psel = 3'b000;
      penable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mrst_prot0", 32'(perr[0]), 32'h0);
      chk("mrst_prot2", 32'(perr[2]), 32'h0);
      chk("mrst_count0", 32'(xcnt[0]), 32'h0);
      chk("mrst_pready0", 32'(pready[0]), 32'h0);
      @(posedge clk); #1;
      xfer(3'b001, 1'b0, 32'h8000_000C, 32'h0, rd, rd0, er, w);
      chk("mrst_word_c", rd, 32'h0);
      xfer(3'b001, 1'b0, 32'h8000_0004, 32'h0, rd, rd0, er, w);
      chk("mrst_word_4", rd, 32'h0);

      // traffic on select bit 1 only
      psel = 3'b010;
      penable = 1'b0;
      pwrite = 1'b1;
      paddr = 32'h8000_0000;
      pwdata = 32'h0000_0077;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      chk("unsel_pready0", 32'(pready[0]), 32'h0);
      chk("unsel_prdata0", prdata[0], 32'h0);
      repeat (4) @(posedge clk);
      #1;
      psel = 3'b000;
      penable = 1'b0;
      @(negedge clk);
      chk("unsel_count0", 32'(xcnt[0]), 32'd2);
      chk("unsel_count1", 32'(xcnt[1]), 32'd1);
      @(posedge clk); #1;
      xfer(3'b001, 1'b0, 32'h8000_0000, 32'h0, rd, rd0, er, w);
      chk("unsel_mem0", rd, 32'h0);
      xfer(3'b010, 1'b0, 32'h8000_0000, 32'h0, rd, rd0, er, w);
      chk("sel1_mem", rd, 32'h0000_0077);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
